fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_skid_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end and decode.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 8;

  localparam logic [PC_W-1:0]    RESET_PC_DEF = PC_W'(0);
  // Bubble encoding; decode treats this word as a no-op.
  localparam logic [INSTR_W-1:0] NOP_INSTR    = INSTR_W'(0);

  // IF/ID pipeline bundle.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;

  // Where the IF/ID register takes its next contents from.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_F2   = 2'd1,
    SRC_SKID = 2'd2,
    SRC_KILL = 2'd3
  } ifid_src_e;

  // Sequential PC increment, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return PC_W'(pc + PC_W'(1));
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               stall_ctrl;
  logic               flush_ctrl;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  // Fetch stage side.
  modport master (
    input  stall_ctrl, flush_ctrl, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid
  );

  // Environment side: hazard unit, instruction memory and decode.
  modport slave (
    output stall_ctrl, flush_ctrl, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid
  );

endinterface

// File: rtl/fetch_skid_reg.sv
// Single-entry hold register for a fetched word that decode cannot take yet.
module fetch_skid_reg
  import fetch_stage_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  ifid_t entry_q;
  ifid_t entry_d;

  // Clear wins over load; a held entry is never overwritten.
  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d.valid = 1'b0;
    end else if (load_i && !entry_q.valid) begin
      entry_d.instr = instr_i;
      entry_d.pc    = pc_i;
      entry_d.valid = 1'b1;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o = entry_q.valid;
  assign instr_o = entry_q.instr;
  assign pc_o    = entry_q.pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, synchronous-read memory tracking (F2),
// stall skid entry and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master fe
);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic               f2_valid_q;
  logic               f2_valid_d;
  logic [PC_W-1:0]    f2_pc_q;
  logic [PC_W-1:0]    f2_pc_d;
  ifid_t              ifid_q;
  ifid_t              ifid_d;
  ifid_src_e          ifid_src;
  logic               skid_load;
  logic               skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               kill;

  assign kill = fe.flush_ctrl | fe.redirect_valid;

  // Next PC, F2 tracking and skid control; flush/redirect > stall > normal.
  always_comb begin
    pc_d       = pc_q;
    f2_valid_d = f2_valid_q;
    f2_pc_d    = pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    ifid_src   = SRC_HOLD;
    if (kill) begin
      f2_valid_d = 1'b0;
      skid_clear = 1'b1;
      if (fe.redirect_valid) begin
        pc_d = fe.redirect_pc;
      end else if (!fe.stall_ctrl) begin
        pc_d = pc_inc(pc_q);
      end
      if (fe.flush_ctrl) begin
        ifid_src = SRC_KILL;
      end
    end else if (fe.stall_ctrl) begin
      // The word now on imem_rdata moves to the skid entry and memory re-reads
      // pc_q. The re-read only counts as live when F2 already carried a live
      // word; otherwise it would be delivered a second time after release.
      skid_load = f2_valid_q && !skid_valid;
    end else begin
      pc_d       = pc_inc(pc_q);
      f2_valid_d = 1'b1;
      ifid_src   = skid_valid ? SRC_SKID : SRC_F2;
      skid_clear = skid_valid;
    end
  end

  // IF/ID source select.
  always_comb begin
    ifid_d = ifid_q;
    unique case (ifid_src)
      SRC_F2: begin
        ifid_d.instr = fe.imem_rdata;
        ifid_d.pc    = f2_pc_q;
        ifid_d.valid = f2_valid_q;
      end
      SRC_SKID: begin
        ifid_d.instr = skid_instr;
        ifid_d.pc    = skid_pc;
        ifid_d.valid = 1'b1;
      end
      SRC_KILL: begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
      default: begin
        ifid_d = ifid_q;
      end
    endcase
  end

  // PC, F2 and IF/ID registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      f2_valid_q <= 1'b0;
      f2_pc_q    <= PC_W'(0);
      ifid_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      f2_valid_q <= f2_valid_d;
      f2_pc_q    <= f2_pc_d;
      ifid_q     <= ifid_d;
    end
  end

  fetch_skid_reg u_skid (
    .clock_i (clock),
    .reset_i (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (fe.imem_rdata),
    .pc_i    (f2_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign fe.imem_addr  = pc_q;
  assign fe.ifid_instr = ifid_q.instr;
  assign fe.ifid_pc    = ifid_q.pc;
  assign fe.ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against an in-order delivery model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;

  fetch_stage_if fe ();

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .fe    (fe)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Synchronous-read instruction memory, mem[n] = 0x1000 + n.
  always @(posedge clock) fe.imem_rdata <= mem_word(fe.imem_addr);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: next address to fetch, queue of fetched-but-undelivered
  // addresses (program order), and the expected IF/ID contents.
  logic [7:0]  m_pc;
  logic [7:0]  m_q[$];
  logic        exp_valid;
  logic [7:0]  exp_pc;
  logic [15:0] exp_instr;
  logic        last_rst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of architectural behaviour.
  task automatic model_edge(input logic rst, input logic st, input logic fl,
                            input logic rd, input logic [7:0] rpc);
    logic [7:0] a;
    if (rst) begin
      m_pc = 8'h00;
      m_q.delete();
      exp_valid = 1'b0;
      exp_pc    = 8'h00;
      exp_instr = 16'h0000;
    end else if (fl || rd) begin
      m_q.delete();
      if (fl) exp_valid = 1'b0;
      if (rd) m_pc = rpc;
      else if (!st) m_pc = m_pc + 8'd1;
    end else if (!st) begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        exp_valid = 1'b1;
        exp_pc    = a;
        exp_instr = mem_word(a);
      end else begin
        exp_valid = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic compare_outputs();
    check("imem_addr", 32'(fe.imem_addr), 32'(m_pc));
    check("ifid_valid", 32'(fe.ifid_valid), 32'(exp_valid));
    if (exp_valid || last_rst) begin
      check("ifid_pc", 32'(fe.ifid_pc), 32'(exp_pc));
      check("ifid_instr", 32'(fe.ifid_instr), 32'(exp_instr));
    end
  endtask

  // Apply inputs for one cycle, advance the model on the edge, then compare.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic rd, input logic [7:0] rpc);
    @(negedge clock);
    reset             = rst;
    fe.stall_ctrl     = st;
    fe.flush_ctrl     = fl;
    fe.redirect_valid = rd;
    fe.redirect_pc    = rpc;
    @(posedge clock);
    model_edge(rst, st, fl, rd, rpc);
    last_rst = rst;
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] wrap_seq [4];
    wrap_seq[0] = 8'hFE; wrap_seq[1] = 8'hFF; wrap_seq[2] = 8'h00; wrap_seq[3] = 8'h01;
    reset = 1'b1;
    fe.stall_ctrl = 1'b0;
    fe.flush_ctrl = 1'b0;
    fe.redirect_valid = 1'b0;
    fe.redirect_pc = 8'h00;
    m_pc = 8'h00;
    exp_valid = 1'b0;
    exp_pc = 8'h00;
    exp_instr = 16'h0000;
    last_rst = 1'b1;

    // Reset, then first valid word two cycles after release.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    check("reset_valid", 32'(fe.ifid_valid), 32'd0);
    check("reset_addr", 32'(fe.imem_addr), 32'h00);
    run(1);
    check("first_bubble", 32'(fe.ifid_valid), 32'd0);
    run(1);
    check("first_valid", 32'(fe.ifid_valid), 32'd1);
    check("first_pc", 32'(fe.ifid_pc), 32'h00);
    check("first_instr", 32'(fe.ifid_instr), 32'h1000);
    run(2);
    check("pc2_before_stall", 32'(fe.ifid_pc), 32'h02);

    // 3-cycle stall holds IF/ID and the PC; release resumes at 3 with no gap.
    for (int i = 0; i < 3; i++) begin
      stall(1);
      check("stall_hold_pc", 32'(fe.ifid_pc), 32'h02);
      check("stall_hold_addr", 32'(fe.imem_addr), 32'h04);
    end
    for (int i = 0; i < 3; i++) begin
      run(1);
      check("release_seq", 32'(fe.ifid_pc), 32'(3 + i));
    end

    // 1-cycle stall and back-to-back stalls (1 on, 1 off, 2 on).
    stall(1); run(2);
    stall(1); run(1); stall(2); run(3);

    // Flush plus redirect to 0x40 while stalled.
    stall(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    check("flush_bubble", 32'(fe.ifid_valid), 32'd0);
    check("redirect_addr", 32'(fe.imem_addr), 32'h40);
    run(1);
    run(1);
    check("redirect_pc_arrives", 32'(fe.ifid_pc), 32'h40);
    check("redirect_instr_arrives", 32'(fe.ifid_instr), 32'h1040);
    run(2);

    // Redirect alone keeps IF/ID; flush alone advances PC.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    run(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    run(3);

    // PC wrap-around.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFE);
    run(1);
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("wrap_seq", 32'(fe.ifid_pc), 32'(wrap_seq[i]));
    end

    // Reset mid-stall with a held skid entry; stale word must never reappear.
    stall(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("midstall_reset_valid", 32'(fe.ifid_valid), 32'd0);
    check("midstall_reset_pc", 32'(fe.ifid_pc), 32'h00);
    run(2);
    check("after_reset_pc", 32'(fe.ifid_pc), 32'h00);
    run(2);

    // Randomised hazard traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rst_r, st_r, fl_r, rd_r;
      logic [7:0] rpc_r;
      rst_r = ($urandom_range(0, 99) < 2);
      st_r  = ($urandom_range(0, 99) < 30);
      fl_r  = ($urandom_range(0, 99) < 6);
      rd_r  = ($urandom_range(0, 99) < 6);
      rpc_r = 8'($urandom);
      step(rst_r, st_r, fl_r, rd_r, rpc_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
